// File: rtl/ex_stage.sv
// Execute stage of a single-cycle LEGv8 datapath.
//
// Purpose: selects ALU operand B, decodes the ALU operation from ALUOp and the
// R-format opcode, produces the ALU result and the branch target, and holds the
// NZCV status register.
//
// Ports:
//   clk      - clock, flags update on rising edge
//   rst_n    - asynchronous reset, ACTIVE-HIGH despite the name (1 clears NZCV)
//   r_data1  - register read data 1 (operand A)
//   r_data2  - register read data 2 (operand B when ALUSrc = 0)
//   ex_data  - sign-extended immediate/offset (operand B when ALUSrc = 1)
//   inst     - current instruction, opcode taken from the top 11 bits
//   ALUOp    - ALU class from the control unit
//   ALUSrc   - operand-B select
//   SregUp   - status-register write enable
//   pc       - address of the current instruction
//   ALUOut   - ALU result (combinational)
//   ALU_res  - branch target pc + (ex_data << 2) (combinational)
//   N/Z/C/V  - registered status flags
module ex_stage #(
  parameter int unsigned WORD      = 64,
  parameter int unsigned INST_SIZE = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WORD-1:0]      r_data1,
  input  logic [WORD-1:0]      r_data2,
  input  logic [WORD-1:0]      ex_data,
  input  logic [INST_SIZE-1:0] inst,
  input  logic [1:0]           ALUOp,
  input  logic                 ALUSrc,
  input  logic                 SregUp,
  input  logic [WORD-1:0]      pc,
  output logic [WORD-1:0]      ALUOut,
  output logic [WORD-1:0]      ALU_res,
  output logic                 N,
  output logic                 Z,
  output logic                 C,
  output logic                 V
);

  localparam logic [10:0] OpcAdd  = 11'h458;
  localparam logic [10:0] OpcAdds = 11'h558;
  localparam logic [10:0] OpcSub  = 11'h658;
  localparam logic [10:0] OpcSubs = 11'h758;
  localparam logic [10:0] OpcAnd  = 11'h450;
  localparam logic [10:0] OpcAnds = 11'h750;
  localparam logic [10:0] OpcOrr  = 11'h550;
  localparam logic [10:0] OpcEor  = 11'h650;

  typedef enum logic [2:0] {
    AluAdd,
    AluSub,
    AluAnd,
    AluOrr,
    AluEor,
    AluPass,
    AluNeq
  } alu_op_e;

  logic [WORD-1:0] op_a;
  logic [WORD-1:0] op_b;
  logic [10:0]     opcode;
  alu_op_e         alu_op;
  logic [WORD:0]   sum_ext;
  logic [WORD:0]   diff_ext;
  logic [WORD-1:0] result;
  logic            c_next;
  logic            v_next;
  logic [3:0]      nzcv_d;
  logic [3:0]      nzcv_q;
  logic            unused_inst;

  assign op_a   = r_data1;
  assign op_b   = ALUSrc ? ex_data : r_data2;
  assign opcode = inst[INST_SIZE-1 -: 11];

  // Only the opcode field matters here; the rest of the instruction is ignored.
  assign unused_inst = ^inst[INST_SIZE-12:0];

  // Branch target is independent of the ALU controls.
  assign ALU_res = pc + {ex_data[WORD-3:0], 2'b00};

  always_comb begin
    alu_op = AluAdd;
    unique case (ALUOp)
      2'b00: alu_op = AluAdd;
      2'b01: alu_op = AluPass;
      2'b11: alu_op = AluNeq;
      default: begin
        case (opcode)
          OpcAdd, OpcAdds: alu_op = AluAdd;
          OpcSub, OpcSubs: alu_op = AluSub;
          OpcAnd, OpcAnds: alu_op = AluAnd;
          OpcOrr:          alu_op = AluOrr;
          OpcEor:          alu_op = AluEor;
          default:         alu_op = AluAdd;
        endcase
      end
    endcase
  end

  // Extra top bit captures the carry out; subtract is A + ~B + 1 so C = no borrow.
  assign sum_ext  = {1'b0, op_a} + {1'b0, op_b};
  assign diff_ext = {1'b0, op_a} + {1'b0, ~op_b} + {{WORD{1'b0}}, 1'b1};

  always_comb begin
    result = sum_ext[WORD-1:0];
    c_next = 1'b0;
    v_next = 1'b0;
    unique case (alu_op)
      AluAdd: begin
        result = sum_ext[WORD-1:0];
        c_next = sum_ext[WORD];
        v_next = (op_a[WORD-1] == op_b[WORD-1]) && (result[WORD-1] != op_a[WORD-1]);
      end
      AluSub: begin
        result = diff_ext[WORD-1:0];
        c_next = diff_ext[WORD];
        v_next = (op_a[WORD-1] != op_b[WORD-1]) && (result[WORD-1] != op_a[WORD-1]);
      end
      AluAnd:  result = op_a & op_b;
      AluOrr:  result = op_a | op_b;
      AluEor:  result = op_a ^ op_b;
      AluPass: result = op_b;
      AluNeq:  result = {{(WORD-1){1'b0}}, (op_a != op_b)};
      default: result = sum_ext[WORD-1:0];
    endcase
  end

  assign ALUOut = result;

  always_comb begin
    nzcv_d = nzcv_q;
    if (SregUp) begin
      nzcv_d = {result[WORD-1], (result == '0), c_next, v_next};
    end
  end

  // Reset input is active-high even though it carries an _n suffix.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      nzcv_q <= 4'b0000;
    end else begin
      nzcv_q <= nzcv_d;
    end
  end

  assign N = nzcv_q[3];
  assign Z = nzcv_q[2];
  assign C = nzcv_q[1];
  assign V = nzcv_q[0];

endmodule

// File: tb/tb_ex_stage.sv
module tb_ex_stage;

  logic        clk;
  logic        rst_n;
  logic [63:0] r_data1;
  logic [63:0] r_data2;
  logic [63:0] ex_data;
  logic [31:0] inst;
  logic [1:0]  ALUOp;
  logic        ALUSrc;
  logic        SregUp;
  logic [63:0] pc;
  logic [63:0] ALUOut;
  logic [63:0] ALU_res;
  logic        N;
  logic        Z;
  logic        C;
  logic        V;

  int n_checks;
  int n_pass;

  ex_stage #(
    .WORD     (64),
    .INST_SIZE(32)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .r_data1(r_data1),
    .r_data2(r_data2),
    .ex_data(ex_data),
    .inst   (inst),
    .ALUOp  (ALUOp),
    .ALUSrc (ALUSrc),
    .SregUp (SregUp),
    .pc     (pc),
    .ALUOut (ALUOut),
    .ALU_res(ALU_res),
    .N      (N),
    .Z      (Z),
    .C      (C),
    .V      (V)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model written from the instruction semantics.
  function automatic void model(input logic [63:0] a, input logic [63:0] b,
                                input logic [1:0] aluop, input logic [10:0] opc,
                                output logic [63:0] res, output logic [3:0] nzcv);
    logic c;
    logic v;
    int   kind;  // 0 add, 1 sub, 2 logical/pass
    c = 1'b0;
    v = 1'b0;
    kind = 2;
    res = a + b;
    if (aluop == 2'b00) begin
      kind = 0;
    end else if (aluop == 2'b01) begin
      res = b;
    end else if (aluop == 2'b11) begin
      res = (a != b) ? 64'd1 : 64'd0;
    end else begin
      if (opc == 11'h458 || opc == 11'h558) kind = 0;
      else if (opc == 11'h658 || opc == 11'h758) kind = 1;
      else if (opc == 11'h450 || opc == 11'h750) res = a & b;
      else if (opc == 11'h550) res = a | b;
      else if (opc == 11'h650) res = a ^ b;
      else kind = 0;
    end
    if (kind == 0) begin
      res = a + b;
      c = (res < a);
      v = (a[63] == b[63]) && (res[63] != a[63]);
    end else if (kind == 1) begin
      res = a - b;
      c = (a >= b);
      v = (a[63] != b[63]) && (res[63] != a[63]);
    end
    nzcv = {res[63], (res == 64'd0), c, v};
  endfunction

  task automatic drive(input logic [63:0] a, input logic [63:0] b2, input logic [63:0] ex,
                       input logic [31:0] in, input logic [1:0] op, input logic src,
                       input logic up, input logic [63:0] p);
    r_data1 = a;
    r_data2 = b2;
    ex_data = ex;
    inst    = in;
    ALUOp   = op;
    ALUSrc  = src;
    SregUp  = up;
    pc      = p;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    drive(64'd0, 64'd1, 64'd0, 32'hCB00_0000, 2'b10, 1'b0, 1'b1, 64'd0);
    n_checks++;
    if ({N, Z, C, V} !== 4'b0000) $display("FAIL reset_flags: got %b want 0000", {N, Z, C, V});
    else n_pass++;
    @(posedge clk); #1;
    n_checks++;
    if ({N, Z, C, V} !== 4'b0000)
      $display("FAIL reset_over_edge: got %b want 0000", {N, Z, C, V});
    else n_pass++;
    rst_n = 1'b0;
    // 0 - 1 would set N and clear Z if captured; SregUp=0 must keep flags clear.
    drive(64'd0, 64'd1, 64'd0, 32'hCB00_0000, 2'b10, 1'b0, 1'b0, 64'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_checks++;
    if ({N, Z, C, V} !== 4'b0000)
      $display("FAIL reset_hold_sregup0: got %b want 0000", {N, Z, C, V});
    else n_pass++;
  endtask

  task automatic test_ldur_stur();
    drive(64'd22, 64'd0, 64'd64, 32'hF840_0000, 2'b00, 1'b1, 1'b0, 64'd200);
    n_checks++;
    if ({ALUOut, ALU_res} !== {64'd86, 64'd456})
      $display("FAIL ldur: got %0d/%0d want 86/456", ALUOut, ALU_res);
    else n_pass++;
    drive(64'd22, 64'd0, 64'd96, 32'hF800_0000, 2'b00, 1'b1, 1'b0, 64'd200);
    n_checks++;
    if ({ALUOut, ALU_res} !== {64'd118, 64'd584})
      $display("FAIL stur: got %0d/%0d want 118/584", ALUOut, ALU_res);
    else n_pass++;
  endtask

  task automatic test_rformat();
    drive(64'd19, 64'd9, 64'h8B09026A, 32'h8B09026A, 2'b10, 1'b0, 1'b0, 64'd200);
    n_checks++;
    if ({ALUOut, ALU_res} !== {64'd28, 64'h2_2C24_0A70})
      $display("FAIL add: got %h/%h want 1c/22c240a70", ALUOut, ALU_res);
    else n_pass++;
    drive(64'd20, 64'd20, 64'hCB0A028B, 32'hCB0A028B, 2'b10, 1'b0, 1'b0, 64'd200);
    n_checks++;
    if ({ALUOut, ALU_res} !== {64'd0, 64'h3_2C28_0AF4})
      $display("FAIL sub: got %h/%h want 0/32c280af4", ALUOut, ALU_res);
    else n_pass++;
    // AND, ORR, EOR on fixed patterns.
    drive(64'hF0F0, 64'h0FF0, 64'd0, 32'h8A00_0000, 2'b10, 1'b0, 1'b0, 64'd0);
    n_checks++;
    if (ALUOut !== 64'h00F0) $display("FAIL and: got %h want 00f0", ALUOut);
    else n_pass++;
    drive(64'hF0F0, 64'h0FF0, 64'd0, 32'hAA00_0000, 2'b10, 1'b0, 1'b0, 64'd0);
    n_checks++;
    if (ALUOut !== 64'hFFF0) $display("FAIL orr: got %h want fff0", ALUOut);
    else n_pass++;
    drive(64'hF0F0, 64'h0FF0, 64'd0, 32'hCA00_0000, 2'b10, 1'b0, 1'b0, 64'd0);
    n_checks++;
    if (ALUOut !== 64'hFF00) $display("FAIL eor: got %h want ff00", ALUOut);
    else n_pass++;
  endtask

  task automatic test_cb();
    drive(64'd0, 64'd0, 64'hFFFF_FFFF_FFFF_FFFB, 32'hB400_0000, 2'b01, 1'b1, 1'b1, 64'd200);
    n_checks++;
    if ({ALUOut, ALU_res} !== {64'hFFFF_FFFF_FFFF_FFFB, 64'd180})
      $display("FAIL cbz_comb: got %h/%0d want fffffffffffffffb/180", ALUOut, ALU_res);
    else n_pass++;
    @(posedge clk); #1;
    n_checks++;
    if ({N, Z, C, V} !== 4'b1000) $display("FAIL cbz_flags: got %b want 1000", {N, Z, C, V});
    else n_pass++;
    drive(64'd0, 64'd0, 64'd8, 32'hB500_0000, 2'b01, 1'b1, 1'b1, 64'd200);
    n_checks++;
    if ({ALUOut, ALU_res} !== {64'd8, 64'hE8})
      $display("FAIL cbnz_comb: got %h/%h want 8/e8", ALUOut, ALU_res);
    else n_pass++;
    @(posedge clk); #1;
    n_checks++;
    if ({N, Z, C, V} !== 4'b0000) $display("FAIL cbnz_flags: got %b want 0000", {N, Z, C, V});
    else n_pass++;
  endtask

  task automatic test_branch();
    drive(64'd2, 64'd0, 64'd64, 32'h1400_0040, 2'b11, 1'b0, 1'b0, 64'd200);
    n_checks++;
    if ({ALUOut, ALU_res} !== {64'd1, 64'd456})
      $display("FAIL b_neq: got %0d/%0d want 1/456", ALUOut, ALU_res);
    else n_pass++;
    drive(64'd7, 64'd7, 64'd64, 32'h1400_0040, 2'b11, 1'b0, 1'b0, 64'd200);
    n_checks++;
    if (ALUOut !== 64'd0) $display("FAIL b_eq: got %0d want 0", ALUOut);
    else n_pass++;
  endtask

  task automatic test_subs_overflow();
    drive(64'h8000_0000_0000_0000, 64'd1, 64'd0, 32'hEB00_0000, 2'b10, 1'b0, 1'b1, 64'd0);
    n_checks++;
    if (ALUOut !== 64'h7FFF_FFFF_FFFF_FFFF)
      $display("FAIL subs_ovf_result: got %h want 7fffffffffffffff", ALUOut);
    else n_pass++;
    @(posedge clk); #1;
    n_checks++;
    if ({N, Z, C, V} !== 4'b0011)
      $display("FAIL subs_ovf_flags: got %b want 0011", {N, Z, C, V});
    else n_pass++;
    // Unsigned add wrap: carry out, zero result, no signed overflow.
    drive(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 32'hAB00_0000, 2'b10, 1'b0, 1'b1, 64'd0);
    @(posedge clk); #1;
    n_checks++;
    if ({N, Z, C, V} !== 4'b0110)
      $display("FAIL adds_carry_flags: got %b want 0110", {N, Z, C, V});
    else n_pass++;
  endtask

  task automatic test_async_reset();
    drive(64'd0, 64'd0, 64'hFFFF_FFFF_FFFF_FFFB, 32'hB400_0000, 2'b01, 1'b1, 1'b1, 64'd200);
    @(posedge clk); #2;
    rst_n = 1'b1;
    #1;
    n_checks++;
    if ({N, Z, C, V} !== 4'b0000)
      $display("FAIL async_reset: got %b want 0000", {N, Z, C, V});
    else n_pass++;
    ex_data = 64'd12;
    #1;
    n_checks++;
    if ({ALUOut, ALU_res} !== {64'd12, 64'd248})
      $display("FAIL comb_during_reset: got %0d/%0d want 12/248", ALUOut, ALU_res);
    else n_pass++;
    @(posedge clk); #1;
    n_checks++;
    if ({N, Z, C, V} !== 4'b0000)
      $display("FAIL reset_beats_edge: got %b want 0000", {N, Z, C, V});
    else n_pass++;
    rst_n = 1'b0;
  endtask

  task automatic test_random();
    logic [10:0] opcs [9];
    logic [63:0] edges [5];
    logic [63:0] a, b2, ex, p, exp_res, exp_ext, bsel;
    logic [3:0]  exp_flags, nz;
    logic [10:0] opc;
    logic [1:0]  op;
    logic        src, up;
    opcs = '{11'h458, 11'h558, 11'h658, 11'h758, 11'h450, 11'h750, 11'h550, 11'h650, 11'h7FF};
    edges = '{64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000,
              64'h7FFF_FFFF_FFFF_FFFF, 64'd1};
    // Sync model with DUT: apply a known update first.
    drive(64'd0, 64'd0, 64'd0, 32'd0, 2'b01, 1'b1, 1'b1, 64'd0);
    @(posedge clk); #1;
    exp_flags = 4'b0100;
    for (int i = 0; i < 300; i++) begin
      a  = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 4)] : {$urandom, $urandom};
      b2 = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 4)] : {$urandom, $urandom};
      ex = {$urandom, $urandom};
      p  = {$urandom, $urandom};
      opc = opcs[$urandom_range(0, 8)];
      if ($urandom_range(0, 4) == 0) opc = 11'($urandom);
      op  = 2'($urandom);
      src = 1'($urandom);
      up  = 1'($urandom);
      drive(a, b2, ex, {opc, 21'($urandom)}, op, src, up, p);
      bsel = src ? ex : b2;
      model(a, bsel, op, opc, exp_res, nz);
      exp_ext = p + ex * 4;
      n_checks++;
      if ({ALUOut, ALU_res} !== {exp_res, exp_ext})
        $display("FAIL rand_comb[%0d]: got %h/%h want %h/%h", i, ALUOut, ALU_res, exp_res,
                 exp_ext);
      else n_pass++;
      if (up) exp_flags = nz;
      @(posedge clk); #1;
      n_checks++;
      if ({N, Z, C, V} !== exp_flags)
        $display("FAIL rand_flags[%0d]: got %b want %b", i, {N, Z, C, V}, exp_flags);
      else n_pass++;
    end
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    test_reset();
    test_ldur_stur();
    test_rformat();
    test_cb();
    test_branch();
    test_subs_overflow();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
